// File: rtl/mem_sram_bridge.sv
// Bridges MEM-stage word/halfword loads and stores onto a 16-bit SRAM,
// stalling the pipeline while the access is split into halfword cycles.
// Ports:
//   clk, rst       : clock, async active-low reset
//   req_*          : MEM-stage request (valid/we/half/addr/wdata)
//   stall          : freezes upstream pipeline registers
//   rdata(_valid)  : load result and one-cycle completion pulse
//   err            : one-cycle pulse for a misaligned request
//   sram_*         : halfword SRAM address/data/strobes
module mem_sram_bridge #(
  parameter int ADDR_W  = 32,
  parameter int SRAM_AW = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic               req_half,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               stall,
  output logic [31:0]        rdata,
  output logic               rdata_valid,
  output logic               err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  output logic               sram_oe,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we,
  output logic               sram_re
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic               lat_we;
  logic               lat_half;
  logic [SRAM_AW-2:0] lat_waddr;
  logic [15:0]        lat_wdata_hi;

  logic               misaligned;
  logic [SRAM_AW-1:0] first_addr;
  logic               unused;

  assign misaligned = req_half ? req_addr[0]
                               : (req_addr[1:0] != 2'b00);

  // Word accesses start at the even halfword; halfwords go direct.
  assign first_addr = req_half ? req_addr[SRAM_AW:1]
                               : {req_addr[SRAM_AW:2], 1'b0};

  // Upper byte-address bits wrap around the SRAM.
  assign unused = ^req_addr[ADDR_W-1:SRAM_AW+1];

  assign stall   = req_valid & (state != DONE);
  assign sram_oe = sram_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_half     <= 1'b0;
      lat_waddr    <= '0;
      lat_wdata_hi <= '0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      err          <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      sram_we      <= 1'b0;
      sram_re      <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_half     <= req_half;
            lat_waddr    <= req_addr[SRAM_AW:2];
            lat_wdata_hi <= req_wdata[31:16];
            if (misaligned) begin
              state       <= DONE;
              err         <= 1'b1;
              rdata_valid <= ~req_we;
              if (!req_we) begin
                rdata <= '0;
              end
            end else begin
              state      <= LO;
              sram_addr  <= first_addr;
              sram_wdata <= req_wdata[15:0];
              sram_we    <= req_we;
              sram_re    <= ~req_we;
            end
          end
        end
        LO: begin
          if (!lat_we) begin
            rdata[15:0] <= sram_rdata;
            if (lat_half) begin
              rdata[31:16] <= {16{sram_rdata[15]}};
            end
          end
          if (lat_half) begin
            state       <= DONE;
            rdata_valid <= ~lat_we;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            sram_we     <= 1'b0;
            sram_re     <= 1'b0;
          end else begin
            state      <= HI;
            sram_addr  <= {lat_waddr, 1'b1};
            sram_wdata <= lat_wdata_hi;
          end
        end
        HI: begin
          if (!lat_we) begin
            rdata[31:16] <= sram_rdata;
          end
          state       <= DONE;
          rdata_valid <= ~lat_we;
          sram_addr   <= '0;
          sram_wdata  <= '0;
          sram_we     <= 1'b0;
          sram_re     <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_sram_bridge.md
Name: mem_sram_bridge

Overview:
- Downstream neighbour of the pipelined CPU's MEM stage: accepts one 32-bit word or 16-bit halfword load/store per request and serialises it onto the 16-bit data SRAM.
- Holds the pipeline via `stall` until the access completes.
- Returns a 32-bit read result; halfword loads are sign-extended.
- Detects misaligned accesses and flags them without touching the SRAM.

Parameters:
- ADDR_W, 32, width of CPU byte address.
- SRAM_AW, 11, width of SRAM halfword address.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  MEM stage has a load/store; held stable while `stall`=1.
- req_we  input  1  1=store, 0=load.
- req_half  input  1  1=16-bit access, 0=32-bit access.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; halfword stores use [15:0].
- stall  output  1  freeze PC/IFID/IDEX/EXMEM.
- rdata  output  32  load result, valid when `rdata_valid`=1.
- rdata_valid  output  1  one-cycle pulse on load completion.
- err  output  1  one-cycle pulse, misaligned request.
- sram_addr  output  SRAM_AW  halfword address.
- sram_wdata  output  16  write data.
- sram_oe  output  1  drive enable for top-level tristate of the SRAM data bus (=`sram_we`).
- sram_rdata  input  16  SRAM read data; combinational from `sram_addr` when `sram_re`=1.
- sram_we  output  1  write strobe; SRAM writes on the rising edge.
- sram_re  output  1  read enable.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=IDLE.
  - `rdata`=0, `rdata_valid`=0, `err`=0, `sram_we`=0, `sram_re`=0, `sram_addr`=0, `sram_wdata`=0.
  - Any access in flight is abandoned. A word store interrupted after LO keeps its low half written; this is accepted.
- States: IDLE, LO, HI, DONE. All SRAM outputs are registered-state decodes; all are 0 in IDLE and DONE.
- IDLE transitions:
  - If `req_valid`=1 and the request is misaligned: `err` pulses in DONE and the next state is DONE. Misaligned means `req_half`=0 with `req_addr[1:0]`≠0, or `req_half`=1 with `req_addr[0]`=1.
  - If `req_valid`=1 and aligned: next state is LO.
  - Otherwise remain in IDLE.
- LO:
  - Word access: `sram_addr`={`req_addr[SRAM_AW:2]`,0}, drives `req_wdata[15:0]`.
  - Halfword access: `sram_addr`=`req_addr[SRAM_AW:1]`, drives `req_wdata[15:0]`.
  - `sram_we`=`req_we`, `sram_re`=~`req_we`.
  - On load, `sram_rdata` is captured into `rdata[15:0]` at the edge.
  - Next state: HI for a word access, DONE for a halfword access.
- HI:
  - `sram_addr`={`req_addr[SRAM_AW:2]`,1}, drives `req_wdata[31:16]`.
  - On load, captures `rdata[31:16]`.
  - Next state: DONE.
- Halfword load: `rdata[31:16]` is the sign extension of `rdata[15]` (`{16{sram_rdata[15]}}`) and is set in the same edge as the LO capture.
- Endianness: little-endian; the low halfword is at the lower SRAM address.
- DONE:
  - `stall`=0.
  - `rdata_valid`=1 for loads; `err`=1 if misaligned.
  - `rdata`=0 after a misaligned load.
  - Next state: IDLE unconditionally.
- `rdata` holds its value until the next load completes or reset.
- `stall` = `req_valid` & (state≠DONE), combinational. Resulting latency:
  - Word access: 3 stall cycles.
  - Halfword access: 2 stall cycles.
  - Misaligned access: 1 stall cycle.
- Back-to-back: a request present in the cycle after DONE is accepted from IDLE with no extra bubble.
- Request dropped mid-access (`req_valid` falls in LO/HI, illegal by contract): the FSM still completes the access using the latched request. Request fields (`req_we`, `req_half`, `req_addr`, `req_wdata`) are latched on IDLE exit.
- Address bits above SRAM_AW are ignored (wrap-around).

Test Plan:
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10:
  - Store: SRAM[8]=0xBEEF, SRAM[9]=0xDEAD.
  - `stall` high for 3 cycles per access.
  - Load: `rdata`=0xDEADBEEF with a 1-cycle `rdata_valid`.
- Halfword load from addr 0x12 with SRAM[9]=0x8001 -> `rdata`=0xFFFF8001. Halfword load with SRAM[9]=0x7FFF -> `rdata`=0x00007FFF. `stall` high 2 cycles each.
- Word load from addr 0x06, and halfword store to addr 0x03:
  - `err` pulses once per request.
  - `sram_we`/`sram_re` never assert.
  - `stall` high 1 cycle; `rdata`=0 for the load.
- Two back-to-back word loads (0x00, 0x04) with `req_valid` held: 8 total cycles, two `rdata_valid` pulses, correct data each.
- `rst` asserted during HI of a word store of 0x12345678 to 0x20:
  - All outputs go to 0 immediately.
  - SRAM[16]=0x5678, SRAM[17] unchanged.
  - After release, the FSM is in IDLE and a new load completes normally.
- Address 0x1010 with SRAM_AW=11 (wrap) -> accesses SRAM[8]/[9].
